// File: rtl/genaxis_axil_reg_demux_pkg.sv
// Package for the AXI-lite register demux: response codes, the per-channel
// FSM state encoding and the timeout completion code.
// Configuration macro: GENAXIS_AXIL_TIMEOUT_SLVERR_EN -- when defined a port
// timeout completes with SLVERR, otherwise with OKAY (legacy behaviour).
package genaxis_axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;
  localparam axil_resp_t RESP_DECERR = 2'b11;

`ifdef GENAXIS_AXIL_TIMEOUT_SLVERR_EN
  localparam axil_resp_t RESP_TIMEOUT = RESP_SLVERR;
`else
  localparam axil_resp_t RESP_TIMEOUT = RESP_OKAY;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } ch_state_t;

endpackage

// File: rtl/genaxis_axil_reg_demux_if.sv
// AXI-lite bus bundle for the register demux.
// slave modport  : used by the demux (accepts AW/W/AR, drives B/R).
// master modport : used by the bus master / testbench.
interface genaxis_axil_reg_demux_if
  import genaxis_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  axil_resp_t            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  axil_resp_t            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/genaxis_axil_reg_demux_ch.sv
// One direction (write or read) of the register demux: accepts a request,
// decodes the port window, drives a one-hot enable until ack or timeout and
// then holds the response until the master takes it.
// Ports: clk/rst; req_* request handshake + address + payload;
// en/addr/pay register-side strobe, in-window address, payload;
// stall/ack/rd_data per-port returns; resp_* response handshake.
module genaxis_axil_reg_demux_ch
  import genaxis_axil_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_PORTS       = 4,
  parameter int PORT_ADDR_WIDTH = 10,
  parameter int TIMEOUT         = 16,
  parameter int PAY_WIDTH       = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [PAY_WIDTH-1:0]            req_pay,
  output logic [NUM_PORTS-1:0]            en,
  output logic [PORT_ADDR_WIDTH-1:0]      addr,
  output logic [PAY_WIDTH-1:0]            pay,
  input  logic [NUM_PORTS-1:0]            stall,
  input  logic [NUM_PORTS-1:0]            ack,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output axil_resp_t                      resp,
  output logic [DATA_WIDTH-1:0]           resp_data
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int HI_W  = ADDR_WIDTH - PORT_ADDR_WIDTH;
  localparam logic [31:0] NP_U  = NUM_PORTS;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  ch_state_t            state;
  logic [IDX_W-1:0]     idx_q;
  logic [7:0]           cnt;
  logic [HI_W-1:0]      addr_hi;
  logic [IDX_W-1:0]     idx_d;
  logic                 out_of_range;

  // Everything above the window is treated as one number: any value at or
  // beyond NUM_PORTS covers both "index too big" and "higher bit set".
  assign addr_hi      = req_addr[ADDR_WIDTH-1:PORT_ADDR_WIDTH];
  assign idx_d        = addr_hi[IDX_W-1:0];
  assign out_of_range = (32'(addr_hi) >= NP_U);

  // Ready is only offered when a request is actually present, so the
  // write side raises awready/wready together for a single cycle.
  assign req_ready = (state == ST_IDLE) && req_valid && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      en         <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp       <= RESP_OKAY;
      resp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (out_of_range) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp       <= RESP_DECERR;
              resp_data  <= '0;
            end else begin
              state <= ST_ACCESS;
              en    <= NUM_PORTS'(1) << idx_d;
              cnt   <= '0;
            end
          end
        end
        ST_ACCESS: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (ack[idx_q]) begin
            state      <= ST_RESP;
            en         <= '0;
            resp_valid <= 1'b1;
            resp       <= RESP_OKAY;
            resp_data  <= rd_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
          end else if (stall[idx_q]) begin
            cnt <= '0;
          end else if (cnt == TO_LAST) begin
            state      <= ST_RESP;
            en         <= '0;
            resp_valid <= 1'b1;
            resp       <= RESP_TIMEOUT;
            resp_data  <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request capture carries no reset: it is only observed while en is high.
  always_ff @(posedge clk) begin
    if (req_ready) begin
      idx_q <= idx_d;
      addr  <= req_addr[PORT_ADDR_WIDTH-1:0];
      pay   <= req_pay;
    end
  end

endmodule

// File: rtl/genaxis_axil_reg_demux.sv
// AXI-lite to multi-port register demux. The byte address selects one of
// NUM_PORTS windows of 2**PORT_ADDR_WIDTH bytes; write and read run as two
// independent single-outstanding channels.
// Ports: clk, rst (async, active-high); s_axil AXI-lite slave bundle;
// reg_wr_* shared write address/data/strobe, one-hot enable, per-port
// wait/ack; reg_rd_* shared read address, one-hot enable, per-port
// data/wait/ack.
// Configuration macro: GENAXIS_AXIL_TIMEOUT_SLVERR_EN (see package).
module genaxis_axil_reg_demux
  import genaxis_axil_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_PORTS       = 4,
  parameter int PORT_ADDR_WIDTH = 10,
  parameter int TIMEOUT         = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  genaxis_axil_reg_demux_if.slave         s_axil,
  output logic [PORT_ADDR_WIDTH-1:0]      reg_wr_addr,
  output logic [DATA_WIDTH-1:0]           reg_wr_data,
  output logic [STRB_WIDTH-1:0]           reg_wr_strb,
  output logic [NUM_PORTS-1:0]            reg_wr_en,
  input  logic [NUM_PORTS-1:0]            reg_wr_wait,
  input  logic [NUM_PORTS-1:0]            reg_wr_ack,
  output logic [PORT_ADDR_WIDTH-1:0]      reg_rd_addr,
  output logic [NUM_PORTS-1:0]            reg_rd_en,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] reg_rd_data,
  input  logic [NUM_PORTS-1:0]            reg_rd_wait,
  input  logic [NUM_PORTS-1:0]            reg_rd_ack
);

  localparam int WPAY_W = DATA_WIDTH + STRB_WIDTH;

  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_resp_data;
  logic                  rd_pay;

  assign s_axil.awready = wr_ready;
  assign s_axil.wready  = wr_ready;

  // Write channel: AW and W are taken as a pair; data+strobe ride as payload.
  genaxis_axil_reg_demux_ch #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_PORTS(NUM_PORTS),
    .PORT_ADDR_WIDTH(PORT_ADDR_WIDTH), .TIMEOUT(TIMEOUT), .PAY_WIDTH(WPAY_W)
  ) u_wr (
    .clk       (clk),
    .rst       (rst),
    .req_valid (s_axil.awvalid && s_axil.wvalid),
    .req_ready (wr_ready),
    .req_addr  (s_axil.awaddr),
    .req_pay   ({s_axil.wdata, s_axil.wstrb}),
    .en        (reg_wr_en),
    .addr      (reg_wr_addr),
    .pay       ({reg_wr_data, reg_wr_strb}),
    .stall     (reg_wr_wait),
    .ack       (reg_wr_ack),
    .rd_data   ('0),
    .resp_valid(s_axil.bvalid),
    .resp_ready(s_axil.bready),
    .resp      (s_axil.bresp),
    .resp_data (wr_resp_data)
  );

  genaxis_axil_reg_demux_ch #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_PORTS(NUM_PORTS),
    .PORT_ADDR_WIDTH(PORT_ADDR_WIDTH), .TIMEOUT(TIMEOUT), .PAY_WIDTH(1)
  ) u_rd (
    .clk       (clk),
    .rst       (rst),
    .req_valid (s_axil.arvalid),
    .req_ready (s_axil.arready),
    .req_addr  (s_axil.araddr),
    .req_pay   (1'b0),
    .en        (reg_rd_en),
    .addr      (reg_rd_addr),
    .pay       (rd_pay),
    .stall     (reg_rd_wait),
    .ack       (reg_rd_ack),
    .rd_data   (reg_rd_data),
    .resp_valid(s_axil.rvalid),
    .resp_ready(s_axil.rready),
    .resp      (s_axil.rresp),
    .resp_data (s_axil.rdata)
  );

endmodule

// File: tb/tb_genaxis_axil_reg_demux.sv
module tb_genaxis_axil_reg_demux;
  localparam int DW = 32, AW = 16, SW = 4, NP = 4, PAW = 10, TO = 16;
`ifdef GENAXIS_AXIL_TIMEOUT_SLVERR_EN
  localparam logic [1:0] TO_RESP = 2'b10;
`else
  localparam logic [1:0] TO_RESP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  genaxis_axil_reg_demux_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) axil ();

  logic [PAW-1:0]   reg_wr_addr, reg_rd_addr;
  logic [DW-1:0]    reg_wr_data;
  logic [SW-1:0]    reg_wr_strb;
  logic [NP-1:0]    reg_wr_en, reg_rd_en;
  logic [NP-1:0]    reg_wr_wait = '0, reg_wr_ack = '0;
  logic [NP-1:0]    reg_rd_wait = '0, reg_rd_ack = '0;
  logic [NP*DW-1:0] rd_bus = '0;

  genaxis_axil_reg_demux #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .NUM_PORTS(NP),
    .PORT_ADDR_WIDTH(PAW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .s_axil(axil),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(rd_bus),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [1:0] resp; logic [31:0] data; } exp_t;
  exp_t wq[$], rq[$];

  // Register-side behaviour of the currently selected port, per direction.
  int            w_delay = 0, w_wait = 0, w_len = -1;
  int            r_delay = 0, r_wait = 0, r_len = -1;
  logic [NP-1:0]  w_mask = '0, r_mask = '0;
  logic [PAW-1:0] w_addr = '0, r_addr = '0;
  logic [DW-1:0]  w_data = '0;
  logic [SW-1:0]  w_strb = '0;
  logic          b_low = 1'b0, r_low = 1'b0;

  // Reference decode: window number, or -1 when no port owns the address.
  function automatic int port_of(input logic [AW-1:0] a);
    int hi = int'(a >> PAW);
    return (hi < NP) ? hi : -1;
  endfunction

  // Expected outcome from the access rules: unmapped -> DECERR; ack arrives
  // within TIMEOUT counted cycles -> OKAY; otherwise the timeout code.
  function automatic logic [1:0] exp_resp(input int p, input int dly);
    if (p < 0) return 2'b11;
    if (dly != 0 && dly <= TO) return 2'b00;
    return TO_RESP;
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input int dly, input int wt,
                          input bit track);
    int p = port_of(a);
    int t = 0;
    exp_t e;
    e.resp = exp_resp(p, dly);
    e.data = '0;
    if (track) wq.push_back(e);
    @(posedge clk); #1;
    axil.awaddr = a; axil.awprot = 3'($urandom); axil.wdata = d; axil.wstrb = s;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (axil.awready) break;
      t++;
      if (t > 300) begin chk("aw_handshake_bound", 0, 1); break; end
    end
    chk("wready_with_awready", axil.wready, axil.awready);
    @(posedge clk); #1;
    w_mask  = (p < 0) ? '0 : NP'(1) << p;
    w_addr  = a[PAW-1:0]; w_data = d; w_strb = s;
    w_delay = dly; w_wait = wt;
    w_len   = !track ? -1 : (p < 0) ? 0 : (dly != 0 && dly <= TO) ? wt + dly : wt + TO;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly, input int wt);
    int p = port_of(a);
    int t = 0;
    exp_t e;
    e.resp = exp_resp(p, dly);
    e.data = (e.resp == 2'b00 && p >= 0 && dly != 0 && dly <= TO) ? rd_bus[p*DW +: DW] : '0;
    rq.push_back(e);
    @(posedge clk); #1;
    axil.araddr = a; axil.arprot = 3'($urandom); axil.arvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (axil.arready) break;
      t++;
      if (t > 300) begin chk("ar_handshake_bound", 0, 1); break; end
    end
    @(posedge clk); #1;
    r_mask  = (p < 0) ? '0 : NP'(1) << p;
    r_addr  = a[PAW-1:0];
    r_delay = dly; r_wait = wt;
    r_len   = (p < 0) ? 0 : (dly != 0 && dly <= TO) ? wt + dly : wt + TO;
    axil.arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((wq.size() != 0 || rq.size() != 0) && t < 400) begin
      @(posedge clk); t++;
    end
    chk("queues_drained", 64'(wq.size() + rq.size()), 0);
    @(posedge clk);
  endtask

  // Write-port responder: wait first, then ack on the programmed cycle;
  // random noise on the non-selected ports must be ignored by the DUT.
  int w_cyc = 0;
  always @(negedge clk) begin
    logic hw, ha;
    logic [7:0] junk;
    hw = 1'b0; ha = 1'b0;
    junk = 8'($urandom);
    if (rst) begin
      w_cyc = 0; reg_wr_ack = '0; reg_wr_wait = '0;
    end else begin
      if (reg_wr_en != '0) begin
        w_cyc++;
        chk("wr_en_mask", 64'(reg_wr_en), 64'(w_mask));
        chk("wr_addr", 64'(reg_wr_addr), 64'(w_addr));
        chk("wr_data_strb", {reg_wr_data, reg_wr_strb}, {w_data, w_strb});
        hw = (w_cyc <= w_wait);
        ha = !hw && w_delay != 0 && w_cyc == w_wait + w_delay;
      end else begin
        if (w_cyc != 0 && w_len >= 0) chk("wr_en_cycles", 64'(w_cyc), 64'(w_len));
        w_cyc = 0;
      end
      reg_wr_wait = (hw ? reg_wr_en : '0) | (junk[3:0] & ~reg_wr_en);
      reg_wr_ack  = (ha ? reg_wr_en : '0) | (junk[7:4] & ~reg_wr_en);
    end
  end

  int r_cyc = 0;
  always @(negedge clk) begin
    logic hw, ha;
    logic [7:0] junk;
    hw = 1'b0; ha = 1'b0;
    junk = 8'($urandom);
    if (rst) begin
      r_cyc = 0; reg_rd_ack = '0; reg_rd_wait = '0;
    end else begin
      if (reg_rd_en != '0) begin
        r_cyc++;
        chk("rd_en_mask", 64'(reg_rd_en), 64'(r_mask));
        chk("rd_addr", 64'(reg_rd_addr), 64'(r_addr));
        hw = (r_cyc <= r_wait);
        ha = !hw && r_delay != 0 && r_cyc == r_wait + r_delay;
      end else begin
        if (r_cyc != 0 && r_len >= 0) chk("rd_en_cycles", 64'(r_cyc), 64'(r_len));
        r_cyc = 0;
      end
      reg_rd_wait = (hw ? reg_rd_en : '0) | (junk[3:0] & ~reg_rd_en);
      reg_rd_ack  = (ha ? reg_rd_en : '0) | (junk[7:4] & ~reg_rd_en);
    end
  end

  // Response readiness: random back-pressure unless forced low.
  always begin
    @(posedge clk); #1;
    axil.bready = b_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    axil.rready = r_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Response monitor / scoreboard.
  logic       b_stall = 1'b0, r_stall = 1'b0;
  logic [1:0] b_prev = '0;
  logic [33:0] r_prev = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      b_stall = 1'b0; r_stall = 1'b0;
    end else begin
      if (axil.bvalid) chk("no_awready_while_bvalid", 64'(axil.awready), 0);
      if (axil.rvalid) chk("no_arready_while_rvalid", 64'(axil.arready), 0);
      if (b_stall) chk("b_held_stable", {axil.bvalid, axil.bresp}, {1'b1, b_prev});
      if (r_stall) chk("r_held_stable", {axil.rvalid, axil.rresp, axil.rdata}, {1'b1, r_prev});
      if (axil.bvalid && axil.bready) begin
        if (wq.size() == 0) chk("unexpected_bvalid", 1, 0);
        else begin
          e = wq.pop_front();
          chk("bresp", 64'(axil.bresp), 64'(e.resp));
        end
      end
      if (axil.rvalid && axil.rready) begin
        if (rq.size() == 0) chk("unexpected_rvalid", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rresp", 64'(axil.rresp), 64'(e.resp));
          chk("rdata", 64'(axil.rdata), 64'(e.data));
        end
      end
      b_stall = axil.bvalid && !axil.bready;
      r_stall = axil.rvalid && !axil.rready;
      b_prev  = axil.bresp;
      r_prev  = {axil.rresp, axil.rdata};
    end
  end

  initial begin
    axil.awaddr = '0; axil.awprot = '0; axil.wdata = '0; axil.wstrb = '0;
    axil.araddr = '0; axil.arprot = '0;
    // Valids high during reset: readies must still stay low.
    axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.arvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {axil.awready, axil.wready, axil.arready}, 0);
    chk("rst_valid", {axil.bvalid, axil.rvalid}, 0);
    chk("rst_en", {reg_wr_en, reg_rd_en}, 0);
    chk("rst_resp_data", {axil.bresp, axil.rresp, axil.rdata}, 0);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write to port 1, ack on the third enable cycle.
    do_write(16'h0404, 32'hA5A5A5A5, 4'hF, 3, 0, 1'b1);
    wait_idle();

    // Read port 3, ack on the first enable cycle.
    rd_bus = {$urandom, $urandom, $urandom, $urandom};
    rd_bus[3*DW +: DW] = 32'h12345678;
    do_read(16'h0C10, 1, 0);
    wait_idle();

    // Unmapped reads: window 4, and a high address bit.
    do_read(16'h1000, 1, 0);
    wait_idle();
    do_read(16'h8004, 1, 0);
    wait_idle();

    // Never-acked write, then the same after 40 cycles of wait.
    do_write(16'h0000, 32'h11112222, 4'h3, 0, 0, 1'b1);
    wait_idle();
    do_write(16'h0008, 32'h33334444, 4'hC, 0, 40, 1'b1);
    wait_idle();

    // Ack on the timeout cycle wins; one cycle later it is too late.
    do_write(16'h0010, 32'h55556666, 4'hF, TO, 0, 1'b1);
    wait_idle();
    rd_bus = {$urandom, $urandom, $urandom, $urandom};
    do_read(16'h0410, TO, 2);
    wait_idle();
    do_read(16'h0414, TO + 1, 0);
    wait_idle();

    // Concurrent write + read on port 2 with bready held low; a second
    // write is presented while the first response is pending.
    b_low = 1'b1;
    rd_bus = {$urandom, $urandom, $urandom, $urandom};
    fork
      begin
        do_write(16'h0800, 32'hDEADBEEF, 4'hF, 2, 0, 1'b1);
        do_write(16'h0804, 32'hCAFEF00D, 4'h5, 1, 0, 1'b1);
      end
      do_read(16'h0808, 2, 0);
      begin
        int t = 0;
        while (!axil.bvalid && t < 100) begin @(posedge clk); t++; end
        repeat (5) @(posedge clk);
        #1 b_low = 1'b0;
      end
    join
    wait_idle();

    // Reset in the middle of an unacked write: abandoned silently.
    do_write(16'h0C00, 32'h0BADF00D, 4'hF, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_en", {reg_wr_en, reg_rd_en}, 0);
    chk("midrst_valid_ready", {axil.bvalid, axil.rvalid, axil.awready, axil.arready}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    do_write(16'h0C08, 32'h87654321, 4'hF, 2, 0, 1'b1);
    wait_idle();

    // Randomized concurrent traffic.
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] wa, ra;
      int wd, rd_d, ww, rw;
      wa = AW'(($urandom_range(0, NP) << PAW) | ($urandom_range(0, 255) << 2));
      ra = AW'(($urandom_range(0, NP) << PAW) | ($urandom_range(0, 255) << 2));
      if ($urandom_range(0, 9) == 0) wa[AW-1] = 1'b1;
      wd   = $urandom_range(0, TO + 2);
      rd_d = $urandom_range(0, TO + 2);
      ww   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      rw   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      rd_bus = {$urandom, $urandom, $urandom, $urandom};
      fork
        do_write(wa, $urandom, 4'($urandom), wd, ww, 1'b1);
        do_read(ra, rd_d, rw);
      join
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
